// File: rtl/tt_alvin_asmar_serial_pkg.sv
// Shared types and constants for the Tiny Tapeout serial transmitter.
// Holds the frame state encoding, the data width and the uo_out pin positions.
package tt_alvin_asmar_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } serial_state_t;

    localparam int DATA_BITS = 8;

    localparam int TX_BIT    = 0;
    localparam int BUSY_BIT  = 1;
    localparam int READY_BIT = 2;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while run is high and pulses
// bit_done on the final cycle of each bit. Held at zero whenever run is low.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    assign bit_done = run && (cnt_r == LAST_CNT);

    // Cycle counter, wrapping on the bit boundary so the next bit starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!run || bit_done) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/tt_um_alvin_asmar_serial_tx.sv
// UART-style transmitter: accepts ui_in on a valid/ready handshake and sends it LSB first
// on an idle-high line. Define SERIAL_TX_PARITY_EN to append an even-parity bit after the data.
module tt_um_alvin_asmar_serial_tx
    import tt_alvin_asmar_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    serial_state_t        state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [2:0]           data_idx_r;
    logic                 stop_idx_r;
    logic                 tx_r;
`ifdef SERIAL_TX_PARITY_EN
    logic                 parity_r;
`endif

    logic valid_s;
    logic busy_s;
    logic ready_s;
    logic accept_s;
    logic bit_done_s;
    logic stop_last_s;
    logic unused_s;

    assign valid_s     = uio_in[0];
    assign busy_s      = (state_r != IDLE);
    assign ready_s     = (state_r == IDLE) && ena;
    assign accept_s    = valid_s && ready_s;
    assign stop_last_s = (STOP_BITS == 1) ? 1'b1 : stop_idx_r;
    assign unused_s    = &{1'b0, uio_in[7:1]};

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (busy_s),
        .bit_done(bit_done_s)
    );

    // Frame FSM; tx_r is loaded with the level of the state being entered so it stays registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            data_idx_r <= 3'd0;
            stop_idx_r <= 1'b0;
            tx_r       <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r    <= START;
                        shift_r    <= ui_in;
                        data_idx_r <= 3'd0;
                        stop_idx_r <= 1'b0;
                        tx_r       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                        parity_r   <= even_parity(ui_in);
`endif
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done_s) begin
                        state_r <= DATA;
                        tx_r    <= shift_r[0];
                    end
                end
                DATA: begin
                    if (bit_done_s) begin
                        shift_r    <= {1'b0, shift_r[DATA_BITS-1:1]};
                        data_idx_r <= data_idx_r + 3'd1;
                        if (data_idx_r == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                            state_r <= PARITY;
                            tx_r    <= parity_r;
`else
                            state_r <= STOP;
                            tx_r    <= 1'b1;
`endif
                        end else begin
                            tx_r <= shift_r[1];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (bit_done_s) begin
                        state_r <= STOP;
                        tx_r    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done_s) begin
                        if (stop_last_s) begin
                            state_r <= IDLE;
                        end else begin
                            stop_idx_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    // Pin mapping; busy and ready decode straight from the registered state.
    always_comb begin
        uo_out            = 8'h00;
        uo_out[TX_BIT]    = tx_r;
        uo_out[BUSY_BIT]  = busy_s;
        uo_out[READY_BIT] = ready_s;
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
